// File: rtl/pong_game_ctrl_if.sv
`timescale 1ns/1ps
// pong_game_ctrl_if: frame/button inputs and position/score outputs of the pong controller.
interface pong_game_ctrl_if;
   localparam int unsigned POS_W   = 16;
   localparam int unsigned SCORE_W = 4;

   logic               frame_tick;
   logic               start;
   logic               l_up;
   logic               l_dn;
   logic               r_up;
   logic               r_dn;
   logic [POS_W-1:0]   paddle_l_y;
   logic [POS_W-1:0]   paddle_r_y;
   logic [POS_W-1:0]   ball_x;
   logic [POS_W-1:0]   ball_y;
   logic [SCORE_W-1:0] score_l;
   logic [SCORE_W-1:0] score_r;
   logic [1:0]         game_state;
   logic               game_over;

   modport master (
      output frame_tick, start, l_up, l_dn, r_up, r_dn,
      input  paddle_l_y, paddle_r_y, ball_x, ball_y, score_l, score_r, game_state, game_over
   );

   modport slave (
      input  frame_tick, start, l_up, l_dn, r_up, r_dn,
      output paddle_l_y, paddle_r_y, ball_x, ball_y, score_l, score_r, game_state, game_over
   );
endinterface

// File: rtl/pong_game_ctrl.sv
`timescale 1ns/1ps
// pong_game_ctrl: match sequencer (IDLE/SERVE/PLAY/SCORE), per-frame paddle moves and ball
// physics with wall/paddle reflection. Define PONG_SPEEDUP_EN to speed the ball up every
// 4th paddle hit (capped at twice the base step); undefined keeps a constant step.
module pong_game_ctrl (
   input  logic            clk,
   input  logic            rst_n,
   pong_game_ctrl_if.slave pong_if
);
   localparam int unsigned POS_W        = 16;
   localparam int unsigned SCORE_W      = 4;
   localparam int unsigned SCREEN_W     = 640;
   localparam int unsigned SCREEN_H     = 480;
   localparam int unsigned PADDLE_X     = 16;
   localparam int unsigned PADDLE_W     = 8;
   localparam int unsigned PADDLE_H     = 64;
   localparam int unsigned BALL_SIZE    = 8;
   localparam int unsigned PADDLE_STEP  = 4;
   localparam int unsigned BALL_STEP    = 2;
   localparam int unsigned SERVE_FRAMES = 60;
   localparam int unsigned WIN_SCORE    = 9;
   localparam int unsigned CNT_W        = $clog2(SERVE_FRAMES + 1);

   localparam logic [POS_W-1:0]   C_SW         = POS_W'(SCREEN_W);
   localparam logic [POS_W-1:0]   C_SH         = POS_W'(SCREEN_H);
   localparam logic [POS_W-1:0]   C_PH         = POS_W'(PADDLE_H);
   localparam logic [POS_W-1:0]   C_BALL       = POS_W'(BALL_SIZE);
   localparam logic [POS_W-1:0]   C_PSTEP      = POS_W'(PADDLE_STEP);
   localparam logic [POS_W-1:0]   C_BSTEP      = POS_W'(BALL_STEP);
   localparam logic [POS_W-1:0]   C_PADDLE_MAX = POS_W'(SCREEN_H - PADDLE_H);
   localparam logic [POS_W-1:0]   C_PADDLE_CTR = POS_W'((SCREEN_H - PADDLE_H) / 2);
   localparam logic [POS_W-1:0]   C_BALL_X0    = POS_W'((SCREEN_W - BALL_SIZE) / 2);
   localparam logic [POS_W-1:0]   C_BALL_Y0    = POS_W'((SCREEN_H - BALL_SIZE) / 2);
   localparam logic [POS_W-1:0]   C_L_FACE     = POS_W'(PADDLE_X + PADDLE_W);
   localparam logic [POS_W-1:0]   C_R_FACE     = POS_W'(SCREEN_W - PADDLE_X - PADDLE_W);
   localparam logic [POS_W-1:0]   C_X_RHIT     = POS_W'(SCREEN_W - PADDLE_X - PADDLE_W - BALL_SIZE);
   localparam logic [POS_W-1:0]   C_Y_MAX      = POS_W'(SCREEN_H - BALL_SIZE);
   localparam logic [SCORE_W-1:0] C_WIN        = SCORE_W'(WIN_SCORE);
   localparam logic [CNT_W-1:0]   C_SERVE      = CNT_W'(SERVE_FRAMES);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SERVE = 2'd1;
   localparam logic [1:0] ST_PLAY  = 2'd2;
   localparam logic [1:0] ST_SCORE = 2'd3;

   logic [1:0]         rst_sync_q;
   logic               rst_int_n;
   logic [1:0]         state_q, state_d;
   logic [POS_W-1:0]   pl_q, pl_d, pr_q, pr_d;
   logic [POS_W-1:0]   bx_q, bx_d, by_q, by_d;
   logic [SCORE_W-1:0] sl_q, sl_d, sr_q, sr_d;
   logic               over_q, over_d;
   logic               dir_x_q, dir_x_d;   // 1 = moving right
   logic               dir_y_q, dir_y_d;   // 1 = moving down
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [POS_W-1:0]   step;
   logic               hit_l, hit_r, miss, won;

   // One paddle step with clamping; both or neither button holds position.
   function automatic logic [POS_W-1:0] paddle_next(input logic [POS_W-1:0] y,
                                                    input logic up, input logic dn);
      paddle_next = y;
      if (up && !dn)
         paddle_next = (y < C_PSTEP) ? '0 : y - C_PSTEP;
      else if (dn && !up)
         paddle_next = (y > C_PADDLE_MAX - C_PSTEP) ? C_PADDLE_MAX : y + C_PSTEP;
   endfunction

   // Score increment that saturates at the winning score.
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      sat_inc = (s >= C_WIN) ? C_WIN : s + SCORE_W'(1);
   endfunction

   // Async assert, two-flop synchronized release of the internal reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

`ifdef PONG_SPEEDUP_EN
   localparam logic [POS_W-1:0] C_BSTEP_MAX = POS_W'(2 * BALL_STEP);
   logic [1:0]       hit_cnt_q, hit_cnt_d;
   logic [POS_W-1:0] step_q, step_d;
   logic             serve_load;

   assign serve_load = (state_d == ST_SERVE) && (state_q != ST_SERVE);

   // Ball speed restarts on every serve and grows by one pixel per 4 paddle hits.
   always_comb begin
      hit_cnt_d = hit_cnt_q;
      step_d    = step_q;
      if (serve_load) begin
         hit_cnt_d = 2'd0;
         step_d    = C_BSTEP;
      end else if (hit_l || hit_r) begin
         hit_cnt_d = hit_cnt_q + 2'd1;
         if (hit_cnt_q == 2'd3 && step_q < C_BSTEP_MAX) step_d = step_q + POS_W'(1);
      end
   end

   // Speed-up registers.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         hit_cnt_q <= 2'd0;
         step_q    <= C_BSTEP;
      end else begin
         hit_cnt_q <= hit_cnt_d;
         step_q    <= step_d;
      end
   end
   assign step = step_q;
`else
   assign step = C_BSTEP;
`endif

   // Next-state logic: match sequencing, paddle moves, ball physics and scoring.
   always_comb begin
      state_d = state_q;
      pl_d    = pl_q;
      pr_d    = pr_q;
      bx_d    = bx_q;
      by_d    = by_q;
      sl_d    = sl_q;
      sr_d    = sr_q;
      over_d  = over_q;
      dir_x_d = dir_x_q;
      dir_y_d = dir_y_q;
      cnt_d   = cnt_q;
      hit_l   = 1'b0;
      hit_r   = 1'b0;
      miss    = 1'b0;
      won     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            pl_d = C_PADDLE_CTR;
            pr_d = C_PADDLE_CTR;
            bx_d = C_BALL_X0;
            by_d = C_BALL_Y0;
            if (pong_if.start) begin
               sl_d    = '0;
               sr_d    = '0;
               over_d  = 1'b0;
               dir_x_d = 1'b1;
               dir_y_d = 1'b1;
               cnt_d   = C_SERVE;
               state_d = ST_SERVE;
            end
         end
         ST_SERVE: begin
            bx_d = C_BALL_X0;
            by_d = C_BALL_Y0;
            if (pong_if.frame_tick) begin
               pl_d  = paddle_next(pl_q, pong_if.l_up, pong_if.l_dn);
               pr_d  = paddle_next(pr_q, pong_if.r_up, pong_if.r_dn);
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q <= CNT_W'(1)) state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (pong_if.frame_tick) begin
               pl_d = paddle_next(pl_q, pong_if.l_up, pong_if.l_dn);
               pr_d = paddle_next(pr_q, pong_if.r_up, pong_if.r_dn);
               if (dir_x_q) begin
                  hit_r = (bx_q + C_BALL <= C_R_FACE) && (bx_q + C_BALL + step > C_R_FACE) &&
                          (by_q + C_BALL > pr_q) && (by_q < pr_q + C_PH);
                  miss  = !hit_r && (bx_q + C_BALL + step > C_SW);
               end else begin
                  hit_l = (bx_q >= C_L_FACE) && (bx_q < C_L_FACE + step) &&
                          (by_q + C_BALL > pl_q) && (by_q < pl_q + C_PH);
                  miss  = !hit_l && (bx_q < step);
               end
               if (miss) begin
                  state_d = ST_SCORE;
               end else begin
                  if (hit_l) begin
                     bx_d    = C_L_FACE;
                     dir_x_d = 1'b1;
                  end else if (hit_r) begin
                     bx_d    = C_X_RHIT;
                     dir_x_d = 1'b0;
                  end else if (dir_x_q) begin
                     bx_d = bx_q + step;
                  end else begin
                     bx_d = bx_q - step;
                  end
                  if (!dir_y_q) begin
                     if (by_q < step) begin
                        by_d    = '0;
                        dir_y_d = 1'b1;
                     end else begin
                        by_d = by_q - step;
                     end
                  end else if (by_q + C_BALL + step > C_SH) begin
                     by_d    = C_Y_MAX;
                     dir_y_d = 1'b0;
                  end else begin
                     by_d = by_q + step;
                  end
               end
            end
         end
         ST_SCORE: begin
            // A ball lost while moving right is the left player's point; the direction
            // is kept so the next serve heads toward the player who conceded.
            if (dir_x_q) begin
               sl_d = sat_inc(sl_q);
               won  = (sl_d == C_WIN);
            end else begin
               sr_d = sat_inc(sr_q);
               won  = (sr_d == C_WIN);
            end
            bx_d = C_BALL_X0;
            by_d = C_BALL_Y0;
            if (won) begin
               over_d  = 1'b1;
               pl_d    = C_PADDLE_CTR;
               pr_d    = C_PADDLE_CTR;
               state_d = ST_IDLE;
            end else begin
               cnt_d   = C_SERVE;
               state_d = ST_SERVE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Game state registers.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q <= ST_IDLE;
         pl_q    <= C_PADDLE_CTR;
         pr_q    <= C_PADDLE_CTR;
         bx_q    <= C_BALL_X0;
         by_q    <= C_BALL_Y0;
         sl_q    <= '0;
         sr_q    <= '0;
         over_q  <= 1'b0;
         dir_x_q <= 1'b1;
         dir_y_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pl_q    <= pl_d;
         pr_q    <= pr_d;
         bx_q    <= bx_d;
         by_q    <= by_d;
         sl_q    <= sl_d;
         sr_q    <= sr_d;
         over_q  <= over_d;
         dir_x_q <= dir_x_d;
         dir_y_q <= dir_y_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pong_if.paddle_l_y = pl_q;
   assign pong_if.paddle_r_y = pr_q;
   assign pong_if.ball_x     = bx_q;
   assign pong_if.ball_y     = by_q;
   assign pong_if.score_l    = sl_q;
   assign pong_if.score_r    = sr_q;
   assign pong_if.game_state = state_q;
   assign pong_if.game_over  = over_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
`timescale 1ns/1ps
// tb_pong_game_ctrl: directed checks of reset, serve timing, paddle clamps, wall and paddle
// reflections, misses, scoring to game over and restart.
module tb_pong_game_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   pong_game_ctrl_if bus ();

   pong_game_ctrl dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .pong_if (bus)
   );

   typedef struct {
      int t;
      int x;
      int y;
      int pl;
      int pr;
      int st;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_idle_centre(input string tag);
      chk({tag, ".pl"}, int'(bus.paddle_l_y), 208);
      chk({tag, ".pr"}, int'(bus.paddle_r_y), 208);
      chk({tag, ".bx"}, int'(bus.ball_x), 316);
      chk({tag, ".by"}, int'(bus.ball_y), 236);
      chk({tag, ".st"}, int'(bus.game_state), 0);
   endtask

   task automatic tick();
      @(negedge clk) bus.frame_tick = 1'b1;
      @(negedge clk) bus.frame_tick = 1'b0;
   endtask

   task automatic set_btn(input logic [3:0] b);
      {bus.l_up, bus.l_dn, bus.r_up, bus.r_dn} = b;
   endtask

   // Button schedule for the first rally, {l_up, l_dn, r_up, r_dn}.
   function automatic logic [3:0] btn_sched(input int t);
      if (t <= 60)              return 4'b1001;
      if (t <= 70)              return 4'b1111;
      if (t <= 104)             return 4'b0100;
      if (t >= 200 && t <= 253) return 4'b0010;
      if (t >= 500 && t <= 533) return 4'b1000;
      return 4'b0000;
   endfunction

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      // Expected ball/paddle/state after PLAY tick t of the first rally.
      vecs.push_back('{1,    318, 238, 204, 212, 2});
      vecs.push_back('{51,   418, 338,   4, 412, 2});
      vecs.push_back('{52,   420, 340,   0, 416, 2});
      vecs.push_back('{60,   436, 356,   0, 416, 2});
      vecs.push_back('{70,   456, 376,   0, 416, 2});
      vecs.push_back('{104,  524, 444, 136, 416, 2});
      vecs.push_back('{118,  552, 472, 136, 416, 2});
      vecs.push_back('{119,  554, 472, 136, 416, 2});
      vecs.push_back('{120,  556, 470, 136, 416, 2});
      vecs.push_back('{146,  608, 418, 136, 416, 2});
      vecs.push_back('{147,  608, 416, 136, 416, 2});
      vecs.push_back('{148,  606, 414, 136, 416, 2});
      vecs.push_back('{355,  192,   0, 136, 200, 2});
      vecs.push_back('{356,  190,   0, 136, 200, 2});
      vecs.push_back('{357,  188,   2, 136, 200, 2});
      vecs.push_back('{439,   24, 166, 136, 200, 2});
      vecs.push_back('{440,   24, 168, 136, 200, 2});
      vecs.push_back('{441,   26, 170, 136, 200, 2});
      vecs.push_back('{732,  608, 194,   0, 200, 2});
      vecs.push_back('{733,  608, 192,   0, 200, 2});
      vecs.push_back('{734,  606, 190,   0, 200, 2});
      vecs.push_back('{1037,   0, 414,   0, 200, 2});
      vecs.push_back('{1038,   0, 414,   0, 200, 3});

      rst_n = 1'b0;
      bus.frame_tick = 1'b0;
      bus.start = 1'b0;
      set_btn(4'b0000);
      repeat (3) @(negedge clk);
      chk_idle_centre("rst");
      chk("rst.sl", int'(bus.score_l), 0);
      chk("rst.sr", int'(bus.score_r), 0);
      chk("rst.go", int'(bus.game_over), 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk_idle_centre("rel");

      // IDLE keeps paddles centred regardless of buttons.
      set_btn(4'b1001);
      repeat (60) tick();
      chk_idle_centre("idle_btn");
      set_btn(4'b0000);

      // Start: one cycle to SERVE.
      @(negedge clk) bus.start = 1'b1;
      chk("pre_start.st", int'(bus.game_state), 0);
      @(negedge clk) bus.start = 1'b0;
      chk("start.st", int'(bus.game_state), 1);

      // SERVE lasts exactly 60 ticks with the ball parked at centre.
      repeat (59) tick();
      chk("serve59.st", int'(bus.game_state), 1);
      chk("serve59.bx", int'(bus.ball_x), 316);
      tick();
      chk("serve60.st", int'(bus.game_state), 2);

      // First rally: clamps, both-button hold, walls, paddle hits, left miss.
      idx = 0;
      for (int t = 1; t <= 1038; t++) begin
         set_btn(btn_sched(t));
         tick();
         if (idx < vecs.size() && vecs[idx].t == t) begin
            chk($sformatf("r1.t%0d.x", t),  int'(bus.ball_x),     vecs[idx].x);
            chk($sformatf("r1.t%0d.y", t),  int'(bus.ball_y),     vecs[idx].y);
            chk($sformatf("r1.t%0d.pl", t), int'(bus.paddle_l_y), vecs[idx].pl);
            chk($sformatf("r1.t%0d.pr", t), int'(bus.paddle_r_y), vecs[idx].pr);
            chk($sformatf("r1.t%0d.st", t), int'(bus.game_state), vecs[idx].st);
            idx++;
         end
      end
      set_btn(4'b0000);
      chk("r1.sr_pending", int'(bus.score_r), 0);
      @(negedge clk);
      chk("r1.score.st", int'(bus.game_state), 1);
      chk("r1.score.sr", int'(bus.score_r), 1);
      chk("r1.score.sl", int'(bus.score_l), 0);
      chk("r1.score.bx", int'(bus.ball_x), 316);
      chk("r1.score.by", int'(bus.ball_y), 236);

      // Rallies 2..9: left paddle parked at 208, ball served left and always missed.
      for (int r = 2; r <= 9; r++) begin
         for (int s = 1; s <= 60; s++) begin
            set_btn((r == 2 && s <= 52) ? 4'b0100 : 4'b0000);
            tick();
            if (s == 59) chk($sformatf("r%0d.serve59.st", r), int'(bus.game_state), 1);
         end
         set_btn(4'b0000);
         chk($sformatf("r%0d.serve60.st", r), int'(bus.game_state), 2);
         if (r == 2) chk("r2.pl", int'(bus.paddle_l_y), 208);
         for (int p = 1; p <= 158; p++) begin
            tick();
            if (p == 1) chk($sformatf("r%0d.p1.x", r), int'(bus.ball_x), 314);
            if (p == 1 && r == 2) chk("r2.p1.y", int'(bus.ball_y), 238);
         end
         chk($sformatf("r%0d.p158.x", r), int'(bus.ball_x), 0);
         chk($sformatf("r%0d.p158.st", r), int'(bus.game_state), 2);
         tick();
         chk($sformatf("r%0d.miss.st", r), int'(bus.game_state), 3);
         @(negedge clk);
         if (r < 9) begin
            chk($sformatf("r%0d.st", r), int'(bus.game_state), 1);
            chk($sformatf("r%0d.sr", r), int'(bus.score_r), r);
            chk($sformatf("r%0d.go", r), int'(bus.game_over), 0);
         end else begin
            chk_idle_centre("win");
            chk("win.sr", int'(bus.score_r), 9);
            chk("win.sl", int'(bus.score_l), 0);
            chk("win.go", int'(bus.game_over), 1);
         end
      end

      // Ticks in IDLE after the match do not restart play.
      repeat (3) tick();
      chk("over_idle.st", int'(bus.game_state), 0);
      chk("over_idle.go", int'(bus.game_over), 1);

      // Restart clears scores and game_over.
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      chk("restart.st", int'(bus.game_state), 1);
      chk("restart.sr", int'(bus.score_r), 0);
      chk("restart.go", int'(bus.game_over), 0);

      // Reset in the middle of PLAY.
      repeat (60) tick();
      set_btn(4'b1000);
      repeat (5) tick();
      set_btn(4'b0000);
      chk("mid.x", int'(bus.ball_x), 326);
      chk("mid.y", int'(bus.ball_y), 246);
      chk("mid.pl", int'(bus.paddle_l_y), 188);
      chk("mid.st", int'(bus.game_state), 2);
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk_idle_centre("arst");
      @(posedge clk) #1;
      chk_idle_centre("arst_cyc");
      chk("arst.sr", int'(bus.score_r), 0);
      chk("arst.go", int'(bus.game_over), 0);
      @(negedge clk) rst_n = 1'b1;
      set_btn(4'b1000);
      repeat (4) tick();
      set_btn(4'b0000);
      chk_idle_centre("post_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
